// File: rtl/forwarding_unit.sv
// Data-hazard forwarding unit for the 5-stage pipeline EX stage.
// Combinational bypass selects plus saturating forward-event counters.
module forwarding_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MEM_RegWrite,
    input  logic        WB_RegWrite,
    input  logic [4:0]  MEM_write_register,
    input  logic [4:0]  WB_write_register,
    input  logic [4:0]  EX_rs,
    input  logic [4:0]  EX_rt,
    input  logic        count_clear,
    output logic [1:0]  Forward_in1_sel,
    output logic [1:0]  Forward_in2_sel,
    output logic [15:0] fwd_mem_count,
    output logic [15:0] fwd_wb_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic        mem_hit_rs;
    logic        mem_hit_rt;
    logic        wb_hit_rs;
    logic        wb_hit_rt;
    logic [1:0]  mem_inc;
    logic [1:0]  wb_inc;
    logic [16:0] mem_sum;
    logic [16:0] wb_sum;
    logic [15:0] mem_cnt_d;
    logic [15:0] mem_cnt_q;
    logic [15:0] wb_cnt_d;
    logic [15:0] wb_cnt_q;

    // Hit detection; r0 is hardwired zero so it never forwards.
    always_comb begin
        mem_hit_rs = MEM_RegWrite && (MEM_write_register != 5'd0)
                     && (MEM_write_register == EX_rs);
        mem_hit_rt = MEM_RegWrite && (MEM_write_register != 5'd0)
                     && (MEM_write_register == EX_rt);
        wb_hit_rs  = WB_RegWrite && (WB_write_register != 5'd0)
                     && (WB_write_register == EX_rs);
        wb_hit_rt  = WB_RegWrite && (WB_write_register != 5'd0)
                     && (WB_write_register == EX_rt);
    end

    // Operand selects; MEM holds the younger value so it wins over WB.
    always_comb begin
        Forward_in1_sel = SEL_RF;
        Forward_in2_sel = SEL_RF;
        if (mem_hit_rs) begin
            Forward_in1_sel = SEL_MEM;
        end else if (wb_hit_rs) begin
            Forward_in1_sel = SEL_WB;
        end
        if (mem_hit_rt) begin
            Forward_in2_sel = SEL_MEM;
        end else if (wb_hit_rt) begin
            Forward_in2_sel = SEL_WB;
        end
    end

    // Next counter values: add 0..2 events, saturate, clear wins.
    always_comb begin
        mem_inc = {1'b0, Forward_in1_sel == SEL_MEM}
                + {1'b0, Forward_in2_sel == SEL_MEM};
        wb_inc  = {1'b0, Forward_in1_sel == SEL_WB}
                + {1'b0, Forward_in2_sel == SEL_WB};
        mem_sum = {1'b0, mem_cnt_q} + {15'd0, mem_inc};
        wb_sum  = {1'b0, wb_cnt_q} + {15'd0, wb_inc};
        mem_cnt_d = mem_sum[16] ? 16'hFFFF : mem_sum[15:0];
        wb_cnt_d  = wb_sum[16] ? 16'hFFFF : wb_sum[15:0];
        if (count_clear) begin
            mem_cnt_d = 16'd0;
            wb_cnt_d  = 16'd0;
        end
    end

    // Counter registers with asynchronous clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_cnt_q <= 16'd0;
            wb_cnt_q  <= 16'd0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            wb_cnt_q  <= wb_cnt_d;
        end
    end

    assign fwd_mem_count = mem_cnt_q;
    assign fwd_wb_count  = wb_cnt_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Testbench for forwarding_unit.
// Vector table for the selects, directed sequences for the counters.
module tb_forwarding_unit;

    logic        clk;
    logic        reset_n;
    logic        MEM_RegWrite;
    logic        WB_RegWrite;
    logic [4:0]  MEM_write_register;
    logic [4:0]  WB_write_register;
    logic [4:0]  EX_rs;
    logic [4:0]  EX_rt;
    logic        count_clear;
    logic [1:0]  Forward_in1_sel;
    logic [1:0]  Forward_in2_sel;
    logic [15:0] fwd_mem_count;
    logic [15:0] fwd_wb_count;

    int n_pass;
    int n_total;

    typedef struct {
        logic       mrw;
        logic       wrw;
        logic [4:0] mwr;
        logic [4:0] wwr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] e1;
        logic [1:0] e2;
    } vec_t;

    vec_t vecs [12];

    forwarding_unit dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .MEM_RegWrite       (MEM_RegWrite),
        .WB_RegWrite        (WB_RegWrite),
        .MEM_write_register (MEM_write_register),
        .WB_write_register  (WB_write_register),
        .EX_rs              (EX_rs),
        .EX_rt              (EX_rt),
        .count_clear        (count_clear),
        .Forward_in1_sel    (Forward_in1_sel),
        .Forward_in2_sel    (Forward_in2_sel),
        .fwd_mem_count      (fwd_mem_count),
        .fwd_wb_count       (fwd_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mrw, input logic wrw,
                         input logic [4:0] mwr, input logic [4:0] wwr,
                         input logic [4:0] rs, input logic [4:0] rt);
        MEM_RegWrite       = mrw;
        WB_RegWrite        = wrw;
        MEM_write_register = mwr;
        WB_write_register  = wwr;
        EX_rs              = rs;
        EX_rt              = rt;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0]  = '{1, 1, 12,  2,  6,  2, 2'b00, 2'b01};
        vecs[1]  = '{1, 1,  2,  2,  6,  2, 2'b00, 2'b10};
        vecs[2]  = '{1, 1,  0,  0,  0,  0, 2'b00, 2'b00};
        vecs[3]  = '{0, 1,  5,  5,  5,  5, 2'b01, 2'b01};
        vecs[4]  = '{1, 1,  3,  3,  3,  3, 2'b10, 2'b10};
        vecs[5]  = '{1, 1,  3,  4,  4,  3, 2'b01, 2'b10};
        vecs[6]  = '{1, 0,  9,  9,  9,  9, 2'b10, 2'b10};
        vecs[7]  = '{0, 0,  9,  9,  9,  9, 2'b00, 2'b00};
        vecs[8]  = '{1, 1,  0,  8,  0,  8, 2'b00, 2'b01};
        vecs[9]  = '{1, 1, 31, 31, 31,  1, 2'b10, 2'b00};
        vecs[10] = '{0, 1,  7,  0,  0,  0, 2'b00, 2'b00};
        vecs[11] = '{1, 1, 17, 17, 16, 18, 2'b00, 2'b00};

        reset_n     = 1'b0;
        count_clear = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check("rst_mem_cnt", 32'(fwd_mem_count), 32'd0);
        check("rst_wb_cnt", 32'(fwd_wb_count), 32'd0);

        // Select table runs with reset held: selects must not care.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].mrw, vecs[i].wrw, vecs[i].mwr,
                  vecs[i].wwr, vecs[i].rs, vecs[i].rt);
            #1;
            check($sformatf("vec%0d_in1", i), 32'(Forward_in1_sel),
                  32'(vecs[i].e1));
            check($sformatf("vec%0d_in2", i), 32'(Forward_in2_sel),
                  32'(vecs[i].e2));
            @(negedge clk);
        end
        check("rst_hold_mem", 32'(fwd_mem_count), 32'd0);
        check("rst_hold_wb", 32'(fwd_wb_count), 32'd0);

        // Counting sequence.
        drive(1, 1, 12, 2, 6, 2);
        step(1);
        reset_n = 1'b1;
        step(1);
        check("seq_wb1", 32'(fwd_wb_count), 32'd1);
        check("seq_mem0", 32'(fwd_mem_count), 32'd0);
        drive(1, 1, 2, 2, 6, 2);
        step(1);
        check("seq_mem1", 32'(fwd_mem_count), 32'd1);
        check("seq_wb1b", 32'(fwd_wb_count), 32'd1);
        drive(1, 1, 0, 0, 0, 0);
        step(2);
        check("seq_r0_mem", 32'(fwd_mem_count), 32'd1);
        check("seq_r0_wb", 32'(fwd_wb_count), 32'd1);
        drive(0, 1, 5, 5, 5, 5);
        step(1);
        check("seq_wb3", 32'(fwd_wb_count), 32'd3);
        step(1);
        check("seq_wb5", 32'(fwd_wb_count), 32'd5);
        check("seq_mem1c", 32'(fwd_mem_count), 32'd1);
        count_clear = 1'b1;
        step(1);
        count_clear = 1'b0;
        check("clr_mem", 32'(fwd_mem_count), 32'd0);
        check("clr_wb", 32'(fwd_wb_count), 32'd0);

        // Saturation: +2 per edge reaches FFFE, then clamps at FFFF.
        drive(1, 0, 7, 0, 7, 7);
        step(32767);
        check("sat_fffe", 32'(fwd_mem_count), 32'hFFFE);
        step(1);
        check("sat_ffff", 32'(fwd_mem_count), 32'hFFFF);
        step(100);
        check("sat_hold", 32'(fwd_mem_count), 32'hFFFF);
        check("sat_wb0", 32'(fwd_wb_count), 32'd0);
        count_clear = 1'b1;
        step(1);
        count_clear = 1'b0;
        check("sat_clr", 32'(fwd_mem_count), 32'd0);

        // Clear wins over a simultaneous increment.
        drive(0, 1, 0, 4, 4, 4);
        count_clear = 1'b1;
        step(1);
        count_clear = 1'b0;
        check("clr_prio", 32'(fwd_wb_count), 32'd0);

        // Asynchronous reset between edges.
        step(3);
        check("pre_rst_wb", 32'(fwd_wb_count), 32'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_wb", 32'(fwd_wb_count), 32'd0);
        check("arst_mem", 32'(fwd_mem_count), 32'd0);
        check("arst_sel1", 32'(Forward_in1_sel), 32'b01);
        drive(1, 0, 9, 0, 9, 3);
        #1;
        check("arst_trk1", 32'(Forward_in1_sel), 32'b10);
        check("arst_trk2", 32'(Forward_in2_sel), 32'b00);
        step(2);
        check("arst_hold", 32'(fwd_mem_count), 32'd0);
        reset_n = 1'b1;
        step(1);
        check("post_rst_mem", 32'(fwd_mem_count), 32'd1);
        check("post_rst_wb", 32'(fwd_wb_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Data-hazard forwarding unit for the 5-stage MIPS pipeline, sitting beside the EX stage. It compares the EX-stage source registers (rs, rt) against the destination registers of the instructions in MEM and WB, and drives the two ALU-operand bypass mux selects combinationally. A small clocked block counts forwarding events for performance monitoring.

## Interface
- Parameters: none (register index width fixed at 5, counter width fixed at 16).
- One clock; reset is asynchronous and active-low.
- `clk`  input  1  rising-edge clock (counters only).
- `reset_n`  input  1  asynchronous active-low reset (counters only).
- `MEM_RegWrite`  input  1  instruction in MEM writes the register file.
- `WB_RegWrite`  input  1  instruction in WB writes the register file.
- `MEM_write_register`  input  5  destination register of the MEM instruction.
- `WB_write_register`  input  5  destination register of the WB instruction.
- `EX_rs`  input  5  rs field of the EX instruction.
- `EX_rt`  input  5  rt field of the EX instruction.
- `count_clear`  input  1  synchronous clear of both counters.
- `Forward_in1_sel`  output  2  ALU operand 1 (rs) source select.
- `Forward_in2_sel`  output  2  ALU operand 2 (rt) source select.
- `fwd_mem_count`  output  16  saturating count of operands forwarded from MEM.
- `fwd_wb_count`  output  16  saturating count of operands forwarded from WB.

## Operation
- Select encoding:
  - 2'b00: register-file/ID-EX value.
  - 2'b10: MEM-stage result.
  - 2'b01: WB-stage result.
  - 2'b11: never driven.
- `Forward_in1_sel` is computed from `EX_rs` by these rules; `Forward_in2_sel` uses the same rules with `EX_rt`.
  - MEM hit: `MEM_RegWrite`=1, `MEM_write_register`!=0 and equal to the source register -> 2'b10.
  - WB hit: otherwise, `WB_RegWrite`=1, `WB_write_register`!=0 and equal to the source register -> 2'b01.
  - Otherwise 2'b00.
- MEM has priority over WB when both match (most recent value).
- Register 0 is never forwarded, even when the RegWrite signals are asserted.
- Both operands are evaluated independently. Both may forward at once, from the same stage or from different stages. rs==rt is legal and yields identical selects.
- Counters:
  - Each cycle, `fwd_mem_count` increments by the number of selects equal to 2'b10 (0, 1 or 2).
  - `fwd_wb_count` increments by the number of selects equal to 2'b01 (0, 1 or 2).
  - Both saturate at 16'hFFFF with no wrap. An increment of 2 from 16'hFFFE yields 16'hFFFF.
- `count_clear`=1 sets both counters to 0 on the next edge. Clear takes priority over increment.

## Timing
- Selects are purely combinational, with zero latency from any input change. They do not depend on `clk` or `reset_n`; they are valid during reset.
- Counters update on the rising `clk` edge from the selects present in that cycle.
- `reset_n` low clears both counters immediately (asynchronous), including in the middle of a run. Counters hold 0 while reset is low.
- Reset deassertion is synchronized by the system. The first count occurs on the first rising edge after `reset_n` goes high.
- Reset values: `fwd_mem_count`=0, `fwd_wb_count`=0. The selects have no reset value (combinational).

## Test plan
- MEM_RegWrite=1, WB_RegWrite=1, MEM_wr=12, WB_wr=2, rs=6, rt=2 -> in1_sel=00, in2_sel=01.
- Same stimulus but MEM_wr=2 and WB_wr=2 -> in2_sel=10 (MEM priority), in1_sel=00. One clock edge -> fwd_mem_count +1, fwd_wb_count unchanged.
- MEM_wr=0, WB_wr=0, rs=rt=0, both RegWrite=1 -> both selects 00, and neither counter moves.
- MEM_RegWrite=0, MEM_wr=5, WB_RegWrite=1, WB_wr=5, rs=rt=5 -> both selects 01; fwd_wb_count +2 per edge.
- Drive both selects to 10 for 70000 cycles -> fwd_mem_count holds 16'hFFFF. Assert count_clear for one edge -> 0.
- Count to a nonzero value, pull reset_n low between edges -> both counters read 0 immediately. Selects still track the inputs during reset.
